bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-master arbiter placed between the bus masters (m0 = processor, m1 = debug/loader master) and the single shared bus that feeds the address-decoding interconnect. It serialises accesses with round-robin fairness, holds bus enables for a fixed access latency, captures read data, and returns a one-cycle acknowledge to the winning master. All bus-side outputs are registered.

## Interface
- `LATENCY`, default 1: cycles bus enables are held per access; legal range 1–15.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `m0_req_i`, `m1_req_i` in 1: access request (level).
- `m0_wr_i`, `m1_wr_i` in 1: 1 = write, 0 = read; valid with req.
- `m0_addr_i`, `m1_addr_i` in 32: byte address.
- `m0_data_i`, `m1_data_i` in 32: write data.
- `m0_ack_o`, `m1_ack_o` out 1: one-cycle completion pulse.
- `m0_data_o`, `m1_data_o` out 32: read data, valid when ack is high.
- `m0_gnt_o`, `m1_gnt_o` out 1: master owns the bus (ACCESS through RESP).
- `bus_rd_en_o`, `bus_wr_en_o` out 1: shared-bus strobes.
- `bus_addr_o`, `bus_data_o` out 32: shared-bus address and write data.
- `bus_data_i` in 32: shared-bus read data.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any req is high, select winner, latch its wr/addr/data, set grant, load count = LATENCY-1, go to ACCESS. Otherwise stay.
- Selection: if one req is high, it wins. If both are high, the master not granted last wins. `last` resets to 1, so m0 wins the first tie.
- ACCESS: `bus_rd_en_o`/`bus_wr_en_o` = latched op. Address and data are driven from latches. Count decrements each cycle. When count = 0, capture `bus_data_i` into the read register (reads only) and go to RESP.
- RESP: strobes low. Winner's ack = 1, winner's data_o = captured word. Update `last`, go to IDLE.
- Write acks return data_o = 0.
- Non-winner ack/data_o stay 0. Master inputs are ignored outside IDLE sampling.
- Masters must hold req/wr/addr/data until ack and must drop req in the cycle after ack unless issuing a new access. A req still high in IDLE after RESP is treated as a new access.
- Reset values: state IDLE, all acks/grants/strobes 0, `bus_addr_o`/`bus_data_o`/all data_o = 0, `last` = 1, count = 0.
- Reset mid-access: strobes drop immediately (asynchronous). The in-flight transaction is lost and no ack is issued.

## Timing
- Request sampled at edge E0 (IDLE).
- Strobes high in cycles E0+1 … E0+LATENCY.
- `bus_data_i` sampled at the edge ending cycle E0+LATENCY.
- Ack high in cycle E0+LATENCY+1.
- IDLE in cycle E0+LATENCY+2.
- Throughput: one access per LATENCY+2 cycles. Back-to-back alternating masters are never starved.
- Strobes are never high in RESP or IDLE. Grants are one-hot or zero.

## Structure
- Shared header `bus_defs.vh`: state encodings, address/data width (32), master count (2).
- Sub-module `rr_select2`: combinational two-way round-robin pick with inputs req[1:0] and last, outputs winner and valid. The FSM, counter and latches stay in `bus_arbiter`.

## Test plan
- m0 read, addr 0x0000_0010, LATENCY=1, bus_data_i = 0xDEAD_BEEF → rd_en high 1 cycle with addr 0x10; m0_ack and m0_data_o = 0xDEADBEEF 2 cycles after sample.
- m1 write, addr 0x8000_0004, data 0x55, LATENCY=3 → wr_en high exactly 3 cycles with addr/data stable; m1_ack in cycle 4; m0 outputs stay 0.
- Both masters request continuously from reset → grants m0, m1, m0, m1. Each ack spaced LATENCY+2 cycles apart.
- m0 requests while m1 is in ACCESS → m0 is not sampled until IDLE; m1 ack first, then m0 served.
- Assert rst in second ACCESS cycle (LATENCY=3) → strobes and grant 0 the same cycle; no ack. After release, a fresh m1 request is served normally with m0 priority restored on tie.
- Read with bus_data_i changing every cycle, LATENCY=2 → data_o equals the value present in the last strobe cycle.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master bus arbiter: widths, master count and
// FSM state encoding.
package bus_arbiter_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned N_MASTERS = 2;
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// Master-side request/response signals plus the shared-bus side of the arbiter.
// The slave modport is the arbiter's view; master is the view of whoever drives it.
interface bus_arbiter_if;
  import bus_arbiter_pkg::*;

  logic              m0_req;
  logic              m1_req;
  logic              m0_wr;
  logic              m1_wr;
  logic [ADDR_W-1:0] m0_addr;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [DATA_W-1:0] m1_wdata;
  logic              m0_ack;
  logic              m1_ack;
  logic [DATA_W-1:0] m0_rdata;
  logic [DATA_W-1:0] m1_rdata;
  logic              m0_gnt;
  logic              m1_gnt;
  logic              bus_rd_en;
  logic              bus_wr_en;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;

  modport slave (
    input  m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr, m0_wdata, m1_wdata,
    input  bus_rdata,
    output m0_ack, m1_ack, m0_rdata, m1_rdata, m0_gnt, m1_gnt,
    output bus_rd_en, bus_wr_en, bus_addr, bus_wdata
  );

  modport master (
    output m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr, m0_wdata, m1_wdata,
    output bus_rdata,
    input  m0_ack, m1_ack, m0_rdata, m1_rdata, m0_gnt, m1_gnt,
    input  bus_rd_en, bus_wr_en, bus_addr, bus_wdata
  );

endinterface

// File: rtl/bus_arbiter_rr_select2.sv
// Combinational two-way round-robin pick. On a tie the master that did not
// own the bus last time wins.
module rr_select2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    winner = 1'b0;
    unique case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter: serialises accesses, holds strobes for
// LATENCY cycles, captures read data and returns a one-cycle ack.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input logic           clk,
  input logic           rst,
  bus_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   owner_q, owner_d;
  logic                   last_q, last_d;
  logic                   wr_q, wr_d;
  logic                   rd_en_q, rd_en_d;
  logic                   wr_en_q, wr_en_d;
  logic [N_MASTERS-1:0]   gnt_q, gnt_d;
  logic [N_MASTERS-1:0]   ack_q, ack_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [DATA_W-1:0]      rdata0_q, rdata0_d;
  logic [DATA_W-1:0]      rdata1_q, rdata1_d;

  logic                   pick;
  logic                   pick_valid;
  logic                   sel_wr;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      sel_wdata;

  rr_select2 u_sel (
    .req    ({bus.m1_req, bus.m0_req}),
    .last   (last_q),
    .winner (pick),
    .valid  (pick_valid)
  );

  assign sel_wr    = pick ? bus.m1_wr    : bus.m0_wr;
  assign sel_addr  = pick ? bus.m1_addr  : bus.m0_addr;
  assign sel_wdata = pick ? bus.m1_wdata : bus.m0_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      wr_q     <= 1'b0;
      rd_en_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      gnt_q    <= '0;
      ack_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      wr_q     <= wr_d;
      rd_en_q  <= rd_en_d;
      wr_en_q  <= wr_en_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Every output is computed one cycle ahead so the bus side comes straight
  // from flops; the ACCESS->RESP transition therefore also loads ack/data.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    owner_d  = owner_q;
    last_d   = last_q;
    wr_d     = wr_q;
    rd_en_d  = rd_en_q;
    wr_en_d  = wr_en_q;
    gnt_d    = gnt_q;
    ack_d    = '0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    unique case (state_q)
      IDLE: begin
        rdata0_d = '0;
        rdata1_d = '0;
        if (pick_valid) begin
          owner_d = pick;
          wr_d    = sel_wr;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          gnt_d   = pick ? 2'b10 : 2'b01;
          rd_en_d = ~sel_wr;
          wr_en_d = sel_wr;
          count_d = CNT_LOAD;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (count_q == '0) begin
          rd_en_d        = 1'b0;
          wr_en_d        = 1'b0;
          ack_d[owner_q] = 1'b1;
          if (owner_q) rdata1_d = wr_q ? '0 : bus.bus_rdata;
          else         rdata0_d = wr_q ? '0 : bus.bus_rdata;
          state_d = RESP;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      RESP: begin
        gnt_d   = '0;
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.m0_ack    = ack_q[0];
  assign bus.m1_ack    = ack_q[1];
  assign bus.m0_gnt    = gnt_q[0];
  assign bus.m1_gnt    = gnt_q[1];
  assign bus.m0_rdata  = rdata0_q;
  assign bus.m1_rdata  = rdata1_q;
  assign bus.bus_rd_en = rd_en_q;
  assign bus.bus_wr_en = wr_en_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: three instances with LATENCY 1, 2 and 3
// exercised one at a time by directed accesses.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int ND = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [ND];
  logic        req   [ND][2];
  logic        wr    [ND][2];
  logic [31:0] addr  [ND][2];
  logic [31:0] wdata [ND][2];
  logic [31:0] bdata [ND];
  logic        ack   [ND][2];
  logic        gnt   [ND][2];
  logic [31:0] rdata [ND][2];
  logic        rd_en [ND];
  logic        wr_en [ND];
  logic [31:0] baddr [ND];
  logic [31:0] bwdata[ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    bus_arbiter_if ifc ();
    assign ifc.m0_req    = req[g][0];
    assign ifc.m1_req    = req[g][1];
    assign ifc.m0_wr     = wr[g][0];
    assign ifc.m1_wr     = wr[g][1];
    assign ifc.m0_addr   = addr[g][0];
    assign ifc.m1_addr   = addr[g][1];
    assign ifc.m0_wdata  = wdata[g][0];
    assign ifc.m1_wdata  = wdata[g][1];
    assign ifc.bus_rdata = bdata[g];
    assign ack[g][0]     = ifc.m0_ack;
    assign ack[g][1]     = ifc.m1_ack;
    assign gnt[g][0]     = ifc.m0_gnt;
    assign gnt[g][1]     = ifc.m1_gnt;
    assign rdata[g][0]   = ifc.m0_rdata;
    assign rdata[g][1]   = ifc.m1_rdata;
    assign rd_en[g]      = ifc.bus_rd_en;
    assign wr_en[g]      = ifc.bus_wr_en;
    assign baddr[g]      = ifc.bus_addr;
    assign bwdata[g]     = ifc.bus_wdata;

    bus_arbiter #(.LATENCY(g + 1)) dut (
      .clk (clk),
      .rst (rst[g]),
      .bus (ifc.slave)
    );
  end

  typedef struct packed {
    logic [1:0]  d;
    logic        m;
    logic [31:0] data;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   cycle = 0;

  always @(posedge clk) cycle++;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(int d, int m, logic [31:0] data);
    exp_t e;
    e.d    = 2'(d);
    e.m    = m[0];
    e.data = data;
    sbq.push_back(e);
  endtask

  // Monitor: every ack pops the scoreboard; grants must never be both high.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < ND; d++) begin
      chk("gnt_onehot", 32'(gnt[d][0] & gnt[d][1]), 32'd0);
      for (int m = 0; m < 2; m++) begin
        if (ack[d][m] === 1'b1) begin
          chk("strobe_with_ack", 32'(rd_en[d] | wr_en[d]), 32'd0);
          if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_ack: dut%0d m%0d data %h, expected no ack", d, m, rdata[d][m]);
          end else begin
            e = sbq.pop_front();
            chk("ack_who", 32'(d * 2 + m), 32'(int'(e.d) * 2 + int'(e.m)));
            chk("ack_data", rdata[d][m], e.data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(int d, int m, int budget);
    int n = 0;
    while (ack[d][m] !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    tests++;
    if (ack[d][m] !== 1'b1) begin
      fails++;
      $display("FAIL wait_ack: dut%0d m%0d no ack within %0d cycles", d, m, budget);
    end
  endtask

  // Single access checked cycle by cycle; vary makes bus read data change
  // every strobe cycle so only the last-cycle value is the right capture.
  task automatic do_access(int d, int m, logic w, logic [31:0] a, logic [31:0] wd,
                           logic [31:0] rv, bit vary);
    int lat = d + 1;
    int o   = 1 - m;
    push_exp(d, m, w ? 32'd0 : rv);
    req[d][m]   = 1'b1;
    wr[d][m]    = w;
    addr[d][m]  = a;
    wdata[d][m] = wd;
    bdata[d]    = rv;
    tick();
    for (int k = 1; k <= lat; k++) begin
      if (vary) bdata[d] = (k == lat) ? rv : (rv ^ 32'(k * 17));
      chk("rd_en", 32'(rd_en[d]), 32'(!w));
      chk("wr_en", 32'(wr_en[d]), 32'(w));
      chk("bus_addr", baddr[d], a);
      if (w) chk("bus_wdata", bwdata[d], wd);
      chk("gnt", 32'(gnt[d][m]), 32'd1);
      chk("other_gnt", 32'(gnt[d][o]), 32'd0);
      chk("ack_early", 32'(ack[d][m]), 32'd0);
      tick();
    end
    bdata[d] = 32'hBAD0_BAD0;
    chk("ack", 32'(ack[d][m]), 32'd1);
    chk("rd_en_resp", 32'(rd_en[d]), 32'd0);
    chk("wr_en_resp", 32'(wr_en[d]), 32'd0);
    chk("gnt_resp", 32'(gnt[d][m]), 32'd1);
    chk("other_ack", 32'(ack[d][o]), 32'd0);
    chk("other_data", rdata[d][o], 32'd0);
    req[d][m] = 1'b0;
    tick();
    chk("gnt_idle", 32'(gnt[d][m]), 32'd0);
    chk("ack_idle", 32'(ack[d][m]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int prev;
    for (int d = 0; d < ND; d++) begin
      rst[d]   = 1'b1;
      bdata[d] = '0;
      for (int m = 0; m < 2; m++) begin
        req[d][m]   = 1'b0;
        wr[d][m]    = 1'b0;
        addr[d][m]  = '0;
        wdata[d][m] = '0;
      end
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      chk("rst_rd_en", 32'(rd_en[d]), 32'd0);
      chk("rst_wr_en", 32'(wr_en[d]), 32'd0);
      chk("rst_gnt0", 32'(gnt[d][0]), 32'd0);
      chk("rst_gnt1", 32'(gnt[d][1]), 32'd0);
      chk("rst_ack0", 32'(ack[d][0]), 32'd0);
      chk("rst_ack1", 32'(ack[d][1]), 32'd0);
      chk("rst_addr", baddr[d], 32'd0);
      chk("rst_wdata", bwdata[d], 32'd0);
      chk("rst_rdata0", rdata[d][0], 32'd0);
      chk("rst_rdata1", rdata[d][1], 32'd0);
    end
    rst[0] = 1'b0;
    rst[2] = 1'b0;
    tick();

    // m0 read, LATENCY 1
    do_access(0, 0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
    // m1 write, LATENCY 3
    do_access(2, 1, 1'b1, 32'h8000_0004, 32'h0000_0055, 32'h0, 1'b0);

    // Both masters request from reset on LATENCY 2: m0, m1, m0, m1
    bdata[1]   = 32'hA5A5_0001;
    addr[1][0] = 32'h100;
    addr[1][1] = 32'h200;
    req[1][0]  = 1'b1;
    req[1][1]  = 1'b1;
    for (int i = 0; i < 4; i++) push_exp(1, i % 2, 32'hA5A5_0001);
    rst[1] = 1'b0;
    prev   = 0;
    for (int i = 0; i < 4; i++) begin
      wait_ack(1, i % 2, 20);
      chk("rr_gnt", 32'(gnt[1][i % 2]), 32'd1);
      if (i > 0) chk("ack_spacing", 32'(cycle - prev), 32'd4);
      prev = cycle;
      if (i == 3) begin
        req[1][0] = 1'b0;
        req[1][1] = 1'b0;
      end
      tick();
    end
    tick();

    // Read data changing every cycle, LATENCY 2
    do_access(1, 0, 1'b0, 32'h0000_0020, 32'h0, 32'h1357_9BDF, 1'b1);

    // m0 arrives while m1 is in ACCESS (LATENCY 3)
    push_exp(2, 1, 32'hCAFE_0001);
    push_exp(2, 0, 32'hCAFE_0002);
    bdata[2]   = 32'hCAFE_0001;
    wr[2][1]   = 1'b0;
    addr[2][1] = 32'h40;
    req[2][1]  = 1'b1;
    tick();
    tick();
    wr[2][0]   = 1'b0;
    addr[2][0] = 32'h44;
    req[2][0]  = 1'b1;
    wait_ack(2, 1, 10);
    chk("m0_waits", 32'(gnt[2][0]), 32'd0);
    req[2][1] = 1'b0;
    bdata[2]  = 32'hCAFE_0002;
    tick();
    wait_ack(2, 0, 10);
    req[2][0] = 1'b0;
    tick();

    // Reset in the second ACCESS cycle; last owner was m0 beforehand
    addr[2][1] = 32'h80;
    req[2][1]  = 1'b1;
    tick();
    tick();
    chk("pre_rst_rd_en", 32'(rd_en[2]), 32'd1);
    rst[2] = 1'b1;
    #1;
    chk("rst_mid_rd_en", 32'(rd_en[2]), 32'd0);
    chk("rst_mid_wr_en", 32'(wr_en[2]), 32'd0);
    chk("rst_mid_gnt", 32'(gnt[2][1]), 32'd0);
    req[2][1] = 1'b0;
    tick();
    tick();
    rst[2] = 1'b0;
    tick();

    // Tie after reset: m0 must win again
    push_exp(2, 0, 32'h7777_0000);
    push_exp(2, 1, 32'h7777_0000);
    bdata[2]   = 32'h7777_0000;
    addr[2][0] = 32'h90;
    addr[2][1] = 32'h94;
    req[2][0]  = 1'b1;
    req[2][1]  = 1'b1;
    wait_ack(2, 0, 10);
    req[2][0] = 1'b0;
    tick();
    wait_ack(2, 1, 10);
    req[2][1] = 1'b0;
    tick();
    tick();

    // Fresh m1 request after reset
    do_access(2, 1, 1'b0, 32'h0000_0088, 32'h0, 32'h2468_ACE0, 1'b0);

    repeat (3) tick();
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL sb_empty: %0d acks outstanding, expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
